alu_rs: RTL and testbench

Reservation station and issue scheduler for the ALU functional unit (`alufu`). It accepts dispatched ALU micro-ops from rename/dispatch, holds them until both source operands are available, and snoops the common data bus (CDB) to capture results. It selects the oldest ready entry and presents it on the `alufu` input port, honouring the unit's `busy` backpressure.

---
 rtl/alu_rs_pkg.sv | 35 +++
 rtl/alu_rs_select.sv | 22 ++
 rtl/alu_rs.sv | 150 +++++++++++++++
 tb/tb_alu_rs.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: the slot layout and the
// CDB wakeup helper used both for held entries and for the dispatch bypass.
package alu_rs_pkg;

  localparam int DATA_W  = 8;
  localparam int ROBID_W = 4;

  typedef struct packed {
    logic                    valid;
    logic [7:0]              operand;
    logic [1:0]              src_rdy;
    logic [1:0][ROBID_W-1:0] src_tag;
    logic [1:0][DATA_W-1:0]  src_val;
    logic [7:0]              wbs;
    logic [7:0]              flags;
    logic [ROBID_W-1:0]      robid;
  } rs_entry_t;

  // Capture a broadcast into every still-waiting source whose tag matches.
  function automatic rs_entry_t rs_wake(input rs_entry_t          e,
                                        input logic               hit_valid,
                                        input logic [ROBID_W-1:0] id,
                                        input logic [DATA_W-1:0]  val);
    rs_entry_t r;
    r = e;
    for (int s = 0; s < 2; s++) begin
      if (e.valid && hit_valid && !e.src_rdy[s] && e.src_tag[s] == id) begin
        r.src_rdy[s] = 1'b1;
        r.src_val[s] = val;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// First-set priority encoder: reports the lowest set bit of the eligible
// vector, which in the compacting queue is the oldest ready entry.
module alu_rs_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found = 1'b1;
        idx   = ($clog2(N))'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the ALU unit: holds dispatched ops until both
// sources are ready, snoops the CDB, and issues oldest-ready-first.
module alu_rs #(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = 8,
  parameter int ROBID_W = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  logic [7:0]                      disp_operand,
  input  logic [1:0]                      disp_src_rdy,
  input  logic [1:0][ROBID_W-1:0]         disp_src_tag,
  input  logic [1:0][DATA_W-1:0]          disp_src_val,
  input  logic [7:0]                      disp_wbs,
  input  logic [7:0]                      disp_flags,
  input  logic [ROBID_W-1:0]              disp_robid,
  input  logic                            cdb_valid,
  input  logic [ROBID_W-1:0]              cdb_id,
  input  logic [DATA_W-1:0]               cdb_val,
  input  logic                            fu_busy,
  output logic                            input_transmit,
  output logic [7:0]                      operand,
  output logic [1:0][DATA_W-1:0]          depvals,
  output logic [7:0]                      wbs,
  output logic [7:0]                      flags,
  output logic [ROBID_W-1:0]              robid,
  output logic [$clog2(ENTRIES+1)-1:0]    occupancy
);

  // Slot storage uses the package struct, so DATA_W/ROBID_W must stay at the
  // package values when this block is instantiated.
  import alu_rs_pkg::rs_entry_t;
  import alu_rs_pkg::rs_wake;

  localparam int OCC_W = $clog2(ENTRIES + 1);
  localparam int IDX_W = $clog2(ENTRIES);

  rs_entry_t          q      [ENTRIES];
  rs_entry_t          woke   [ENTRIES];
  rs_entry_t          q_nxt  [ENTRIES];
  rs_entry_t          disp_entry;
  rs_entry_t          sel_entry;
  logic [ENTRIES-1:0] eligible;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               slot_load;
  logic               remove;
  logic               accept;
  logic [OCC_W-1:0]   occ_after;

  // Handshakes: dispatch transfers when disp_valid && disp_ready at a rising
  // edge; the issue slot transfers when input_transmit && !fu_busy, and while
  // input_transmit && fu_busy the whole issue payload is held stable.
  assign disp_ready = !rst && (occupancy < OCC_W'(ENTRIES));
  assign accept     = disp_valid && disp_ready;
  assign slot_load  = !input_transmit || !fu_busy;
  assign remove     = slot_load && sel_found;
  assign occ_after  = occupancy - OCC_W'(remove);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      eligible[i] = q[i].valid && (&q[i].src_rdy);
    end
  end

  alu_rs_select #(.N(ENTRIES)) u_select (
    .eligible (eligible),
    .found    (sel_found),
    .idx      (sel_idx)
  );

  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel_idx == IDX_W'(i)) sel_entry = q[i];
    end
  end

  // The incoming op sees this cycle's broadcast too, so a coincident tag
  // cannot slip past it.
  always_comb begin
    disp_entry         = '0;
    disp_entry.valid   = 1'b1;
    disp_entry.operand = disp_operand;
    disp_entry.src_rdy = disp_src_rdy;
    disp_entry.src_tag = disp_src_tag;
    disp_entry.src_val = disp_src_val;
    disp_entry.wbs     = disp_wbs;
    disp_entry.flags   = disp_flags;
    disp_entry.robid   = disp_robid;
    disp_entry         = rs_wake(disp_entry, cdb_valid, cdb_id, cdb_val);
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      woke[i] = rs_wake(q[i], cdb_valid, cdb_id, cdb_val);
    end
  end

  // Compaction: entries above the issued one slide down, keeping index 0 oldest;
  // the new op lands just above the surviving entries.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      q_nxt[i] = woke[i];
    end
    if (remove) begin
      for (int i = 0; i < ENTRIES - 1; i++) begin
        if (i >= int'(sel_idx)) q_nxt[i] = woke[i+1];
      end
      q_nxt[ENTRIES-1] = '0;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (accept && occ_after == OCC_W'(i)) q_nxt[i] = disp_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) q[i] <= '0;
      occupancy      <= '0;
      input_transmit <= 1'b0;
      operand        <= '0;
      depvals        <= '0;
      wbs            <= '0;
      flags          <= '0;
      robid          <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) q[i] <= '0;
      occupancy      <= '0;
      input_transmit <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) q[i] <= q_nxt[i];
      occupancy <= occ_after + OCC_W'(accept);
      if (slot_load) begin
        input_transmit <= sel_found;
        if (sel_found) begin
          operand <= sel_entry.operand;
          depvals <= sel_entry.src_val;
          wbs     <= sel_entry.wbs;
          flags   <= sel_entry.flags;
          robid   <= sel_entry.robid;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: drivers push hand-computed issue payloads into a
// queue, and an independent monitor pops and compares on every FU transfer.
module tb_alu_rs;

  localparam int PW = 44;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            disp_valid = 1'b0;
  logic            disp_ready;
  logic [7:0]      disp_operand = '0;
  logic [1:0]      disp_src_rdy = '0;
  logic [1:0][3:0] disp_src_tag = '0;
  logic [1:0][7:0] disp_src_val = '0;
  logic [7:0]      disp_wbs = '0;
  logic [7:0]      disp_flags = '0;
  logic [3:0]      disp_robid = '0;
  logic            cdb_valid = 1'b0;
  logic [3:0]      cdb_id = '0;
  logic [7:0]      cdb_val = '0;
  logic            fu_busy = 1'b0;
  logic            input_transmit;
  logic [7:0]      operand;
  logic [1:0][7:0] depvals;
  logic [7:0]      wbs;
  logic [7:0]      flags;
  logic [3:0]      robid;
  logic [2:0]      occupancy;

  logic [PW-1:0]   act_payload;
  logic [PW-1:0]   exp_q[$];
  int              n_checks = 0;
  int              n_fail = 0;

  assign act_payload = {operand, depvals, wbs, flags, robid};

  alu_rs dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_operand(disp_operand), .disp_src_rdy(disp_src_rdy),
    .disp_src_tag(disp_src_tag), .disp_src_val(disp_src_val),
    .disp_wbs(disp_wbs), .disp_flags(disp_flags), .disp_robid(disp_robid),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
    .fu_busy(fu_busy), .input_transmit(input_transmit),
    .operand(operand), .depvals(depvals), .wbs(wbs), .flags(flags),
    .robid(robid), .occupancy(occupancy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pack(input logic [7:0] op, input logic [7:0] v0,
                                         input logic [7:0] v1, input logic [7:0] w,
                                         input logic [7:0] f, input logic [3:0] id);
    return {op, v1, v0, w, f, id};
  endfunction

  // drivers: every task starts and ends 1ns after a rising edge
  task automatic dispatch(input logic [7:0] op, input logic [1:0] rdy,
                          input logic [3:0] tag0, input logic [3:0] tag1,
                          input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] w, input logic [7:0] f,
                          input logic [3:0] id);
    disp_valid      = 1'b1;
    disp_operand    = op;
    disp_src_rdy    = rdy;
    disp_src_tag[0] = tag0;
    disp_src_tag[1] = tag1;
    disp_src_val[0] = v0;
    disp_src_val[1] = v1;
    disp_wbs        = w;
    disp_flags      = f;
    disp_robid      = id;
    @(posedge clk); #1;
    disp_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] id, input logic [7:0] val);
    cdb_valid = 1'b1;
    cdb_id    = id;
    cdb_val   = val;
    @(posedge clk); #1;
    cdb_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || input_transmit) && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, 64'(cyc < 30), 64'd1);
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic          hold_prev = 1'b0;
    logic [PW-1:0] hold_payload = '0;
    logic [PW-1:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", 64'(input_transmit), 64'd1);
          check("hold_payload", 64'(act_payload), 64'(hold_payload));
        end
        if (input_transmit && !fu_busy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_unexpected: got %0h expected no issue at %0t", act_payload, $time);
          end else begin
            exp = exp_q.pop_front();
            check("issue_payload", 64'(act_payload), 64'(exp));
          end
        end
        hold_prev    = input_transmit && fu_busy && !flush;
        hold_payload = act_payload;
      end
    end
  end

  initial begin : main
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_disp_ready", 64'(disp_ready), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_transmit", 64'(input_transmit), 64'd0);
    check("rst_payload", 64'(act_payload), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(disp_ready), 64'd1);
    @(posedge clk); #1;

    // 1: ready dispatch issues one edge after acceptance
    exp_q.push_back(pack(8'h04, 8'd10, 8'd20, 8'h31, 8'h5A, 4'd1));
    dispatch(8'h04, 2'b11, 4'd0, 4'd0, 8'd10, 8'd20, 8'h31, 8'h5A, 4'd1);
    @(negedge clk);
    check("t1_not_yet", 64'(input_transmit), 64'd0);
    @(negedge clk);
    check("t1_issue", 64'(input_transmit), 64'd1);
    @(negedge clk);
    check("t1_one_cycle", 64'(input_transmit), 64'd0);
    @(posedge clk); #1;

    // 2: src0 waits on tag 3, woken by CDB two cycles later
    exp_q.push_back(pack(8'h05, 8'd7, 8'd5, 8'h32, 8'h01, 4'd2));
    dispatch(8'h05, 2'b10, 4'd3, 4'd0, 8'd0, 8'd5, 8'h32, 8'h01, 4'd2);
    idle(2);
    @(negedge clk);
    check("t2_waiting", 64'(input_transmit), 64'd0);
    @(posedge clk); #1;
    cdb(4'd3, 8'd7);
    @(negedge clk);
    check("t2_not_yet", 64'(input_transmit), 64'd0);
    @(negedge clk);
    check("t2_issue", 64'(input_transmit), 64'd1);
    @(posedge clk); #1;
    wait_drain("t2_drain");

    // 3: broadcast coincident with dispatch
    exp_q.push_back(pack(8'h06, 8'h22, 8'd9, 8'h33, 8'h02, 4'd3));
    cdb_valid = 1'b1;
    cdb_id    = 4'd3;
    cdb_val   = 8'h22;
    dispatch(8'h06, 2'b10, 4'd3, 4'd0, 8'd0, 8'd9, 8'h33, 8'h02, 4'd3);
    cdb_valid = 1'b0;
    wait_drain("t3_bypass_drain");

    // 4: fill the station with ops waiting on tags 8..B
    for (int i = 0; i < 4; i++) begin
      dispatch(8'h10 + 8'(i), 2'b10, 4'(8 + i), 4'd0, 8'd0, 8'(i),
               8'h40 + 8'(i), 8'h80 + 8'(i), 4'(4 + i));
    end
    @(negedge clk);
    check("t4_full_occ", 64'(occupancy), 64'd4);
    check("t4_full_ready", 64'(disp_ready), 64'd0);
    @(posedge clk); #1;
    dispatch(8'h99, 2'b11, 4'd0, 4'd0, 8'd1, 8'd1, 8'h00, 8'h00, 4'd8);
    @(negedge clk);
    check("t4_fifth_ignored", 64'(occupancy), 64'd4);
    @(posedge clk); #1;
    exp_q.push_back(pack(8'h12, 8'h77, 8'd2, 8'h42, 8'h82, 4'd6));
    cdb(4'hA, 8'h77);
    @(negedge clk);
    @(negedge clk);
    check("t4_third_issues", 64'(robid), 64'd6);
    check("t4_occ_after", 64'(occupancy), 64'd3);
    check("t4_ready_back", 64'(disp_ready), 64'd1);
    @(posedge clk); #1;
    wait_drain("t4_drain");

    // 5: backpressure holds the slot; next ready op loads after busy falls
    fu_busy = 1'b1;
    exp_q.push_back(pack(8'h20, 8'h11, 8'h12, 8'h50, 8'h60, 4'd9));
    dispatch(8'h20, 2'b11, 4'd0, 4'd0, 8'h11, 8'h12, 8'h50, 8'h60, 4'd9);
    idle(1);
    exp_q.push_back(pack(8'h10, 8'h88, 8'd0, 8'h40, 8'h80, 4'd4));
    cdb(4'd8, 8'h88);
    idle(2);
    @(negedge clk);
    check("t5_no_loss_occ", 64'(occupancy), 64'd3);
    check("t5_held_robid", 64'(robid), 64'd9);
    @(posedge clk); #1;
    fu_busy = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_next_loaded", 64'(robid), 64'd4);
    check("t5_next_valid", 64'(input_transmit), 64'd1);
    @(posedge clk); #1;
    wait_drain("t5_drain");

    // 6: flush with 3 entries and a loaded slot
    fu_busy = 1'b1;
    dispatch(8'h30, 2'b11, 4'd0, 4'd0, 8'd1, 8'd2, 8'h00, 8'h00, 4'd12);
    dispatch(8'h31, 2'b10, 4'hC, 4'd0, 8'd0, 8'd3, 8'h00, 8'h00, 4'd13);
    @(negedge clk);
    check("t6_pre_occ", 64'(occupancy), 64'd3);
    check("t6_pre_slot", 64'(input_transmit), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t6_flush_occ", 64'(occupancy), 64'd0);
    check("t6_flush_slot", 64'(input_transmit), 64'd0);
    check("t6_flush_ready", 64'(disp_ready), 64'd1);
    @(posedge clk); #1;
    fu_busy = 1'b0;
    cdb(4'd9, 8'h55);
    idle(2);
    exp_q.push_back(pack(8'h44, 8'hA1, 8'hB2, 8'h0E, 8'hF0, 4'd14));
    dispatch(8'h44, 2'b11, 4'd0, 4'd0, 8'hA1, 8'hB2, 8'h0E, 8'hF0, 4'd14);
    wait_drain("t6_after_flush");
    idle(3);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
